// File: rtl/reduce_gate_pipe.sv
// Pipelined WIDTH-input AND/OR/XOR/NAND reduction tree, one register stage per tree level.
// Define REDUCE_GATE_COUNT_EN to add the saturating ones_count output.
module reduce_gate_pipe #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_f,
  output logic             out_valid,
  input  logic             out_ready
`ifdef REDUCE_GATE_COUNT_EN
  ,
  output logic [15:0]      ones_count
`endif
);

  localparam int LEVELS = (WIDTH < 2) ? 1 : $clog2(WIDTH);
  localparam int NL     = 1 << (LEVELS - 1);
  localparam int NLEAF  = 2 * NL;

  localparam logic [1:0] MODE_AND  = 2'b00;
  localparam logic [1:0] MODE_OR   = 2'b01;
  localparam logic [1:0] MODE_XOR  = 2'b10;
  localparam logic [1:0] MODE_NAND = 2'b11;

  function automatic logic base_op(input logic [1:0] mode, input logic a, input logic b);
    case (mode)
      MODE_OR:  return a | b;
      MODE_XOR: return a ^ b;
      default:  return a & b;
    endcase
  endfunction

  function automatic logic pad_bit(input logic [1:0] mode);
    return (mode == MODE_AND) || (mode == MODE_NAND);
  endfunction

  logic [NLEAF-1:0]      leaf_w;
  logic [NLEAF-2:0]      node_q, node_d;
  logic [2*NLEAF-2:0]    all_w;
  logic [LEVELS-1:0]     vld_q;
  logic [LEVELS:0]       vld_all;
  logic [LEVELS-1:0][1:0] mode_q;
  logic [LEVELS:0][1:0]  mode_all;
  logic                  stall_w;

  // Stage s occupies node_q[NLEAF-2*(NL>>s) +: NL>>s]; leaves sit below node_q in all_w,
  // so each stage reads its children from one uniform heap-style index.
  always_comb begin
    leaf_w = {NLEAF{pad_bit(in_mode)}};
    leaf_w[WIDTH-1:0] = in_data;
  end

  assign all_w    = {node_q, leaf_w};
  assign vld_all  = {vld_q, in_valid};
  assign mode_all = {mode_q, in_mode};

  always_comb begin
    node_d = '0;
    for (int s = 0; s < LEVELS; s++) begin
      for (int i = 0; i < (NL >> s); i++) begin
        node_d[NLEAF - 2*(NL >> s) + i] =
          base_op(mode_all[s], all_w[2*NLEAF - 4*(NL >> s) + 2*i],
                  all_w[2*NLEAF - 4*(NL >> s) + 2*i + 1]);
      end
    end
  end

  assign stall_w   = vld_all[LEVELS] && !out_ready;
  assign in_ready  = !stall_w;
  assign out_valid = vld_all[LEVELS];
  // Gating with valid keeps out_f at 0 out of reset without resetting the datapath.
  assign out_f     = vld_all[LEVELS] & (all_w[2*NLEAF-2] ^ (mode_all[LEVELS] == MODE_NAND));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
    end else if (!stall_w) begin
      vld_q <= vld_all[LEVELS-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!stall_w) begin
      node_q <= node_d;
      mode_q <= mode_all[LEVELS-1:0];
    end
  end

`ifdef REDUCE_GATE_COUNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (out_valid && out_ready && out_f && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign ones_count = cnt_q;
`endif

endmodule

// File: tb/tb_reduce_gate_pipe.sv
// Directed bench for reduce_gate_pipe at WIDTH=4, 5 and 1; counter checks need REDUCE_GATE_COUNT_EN.
module tb_reduce_gate_pipe;

  localparam logic [1:0] M_AND = 2'b00, M_OR = 2'b01, M_XOR = 2'b10, M_NAND = 2'b11;

  logic clk, reset;
  logic [3:0] din4;  logic [1:0] mode4; logic vin4, irdy4, f4, ov4, rdy4;
  logic [4:0] din5;  logic [1:0] mode5; logic vin5, irdy5, f5, ov5, rdy5;
  logic [0:0] din1;  logic [1:0] mode1; logic vin1, irdy1, f1, ov1, rdy1;
`ifdef REDUCE_GATE_COUNT_EN
  logic [15:0] cnt4, cnt5, cnt1;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  reduce_gate_pipe #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .in_data(din4), .in_mode(mode4), .in_valid(vin4),
    .in_ready(irdy4), .out_f(f4), .out_valid(ov4), .out_ready(rdy4)
`ifdef REDUCE_GATE_COUNT_EN
    , .ones_count(cnt4)
`endif
  );

  reduce_gate_pipe #(.WIDTH(5)) dut5 (
    .clk(clk), .reset(reset), .in_data(din5), .in_mode(mode5), .in_valid(vin5),
    .in_ready(irdy5), .out_f(f5), .out_valid(ov5), .out_ready(rdy5)
`ifdef REDUCE_GATE_COUNT_EN
    , .ones_count(cnt5)
`endif
  );

  reduce_gate_pipe #(.WIDTH(1)) dut1 (
    .clk(clk), .reset(reset), .in_data(din1), .in_mode(mode1), .in_valid(vin1),
    .in_ready(irdy1), .out_f(f1), .out_valid(ov1), .out_ready(rdy1)
`ifdef REDUCE_GATE_COUNT_EN
    , .ones_count(cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         dut;
    logic [4:0] data;
    logic [1:0] mode;
    logic       exp;
  } vec_t;

  vec_t vecs[23];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input int d, input logic [4:0] data, input logic [1:0] mode, input logic v);
    case (d)
      0:       begin din4 = data[3:0]; mode4 = mode; vin4 = v; end
      1:       begin din5 = data;      mode5 = mode; vin5 = v; end
      default: begin din1 = data[0];   mode1 = mode; vin1 = v; end
    endcase
  endtask

  function automatic logic ov_of(input int d);
    case (d)
      0:       return ov4;
      1:       return ov5;
      default: return ov1;
    endcase
  endfunction

  function automatic logic f_of(input int d);
    case (d)
      0:       return f4;
      1:       return f5;
      default: return f1;
    endcase
  endfunction

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : (d == 1) ? 3 : 1;
  endfunction

  // Linear fold over the real bits only.
  function automatic logic model(input logic [4:0] data, input int w, input logic [1:0] mode);
    logic r;
    r = (mode == M_AND) || (mode == M_NAND);
    for (int i = 0; i < w; i++) begin
      case (mode)
        M_OR:    r = r | data[i];
        M_XOR:   r = r ^ data[i];
        default: r = r & data[i];
      endcase
    end
    return (mode == M_NAND) ? ~r : r;
  endfunction

  task automatic run_vec(input int d, input logic [4:0] data, input logic [1:0] mode,
                         input logic exp, input string tag);
    int lat;
    lat = lat_of(d);
    drive(d, data, mode, 1'b1);
    for (int c = 1; c <= lat; c++) begin
      @(posedge clk); #1;
      if (c == 1) drive(d, data, mode, 1'b0);
      if (c < lat) chk({tag, "_early"}, 32'(ov_of(d)), 32'd0);
    end
    chk({tag, "_valid"}, 32'(ov_of(d)), 32'd1);
    chk({tag, "_f"}, 32'(f_of(d)), 32'(exp));
    @(posedge clk); #1;
    chk({tag, "_drain"}, 32'(ov_of(d)), 32'd0);
  endtask

  initial begin
    logic [4:0] b2b_data[8];
    logic [1:0] b2b_mode[8];

    vecs[0]  = '{0, 5'b01111, M_AND,  1'b1};
    vecs[1]  = '{0, 5'b01011, M_AND,  1'b0};
    vecs[2]  = '{0, 5'b00000, M_OR,   1'b0};
    vecs[3]  = '{0, 5'b00111, M_XOR,  1'b1};
    vecs[4]  = '{0, 5'b01111, M_NAND, 1'b0};
    vecs[5]  = '{0, 5'b00010, M_OR,   1'b1};
    vecs[6]  = '{0, 5'b01011, M_NAND, 1'b1};
    vecs[7]  = '{0, 5'b01010, M_XOR,  1'b0};
    vecs[8]  = '{1, 5'b11111, M_AND,  1'b1};
    vecs[9]  = '{1, 5'b10000, M_OR,   1'b1};
    vecs[10] = '{1, 5'b00001, M_XOR,  1'b1};
    vecs[11] = '{1, 5'b01111, M_AND,  1'b0};
    vecs[12] = '{1, 5'b10000, M_XOR,  1'b1};
    vecs[13] = '{1, 5'b11111, M_NAND, 1'b0};
    vecs[14] = '{1, 5'b00000, M_OR,   1'b0};
    vecs[15] = '{1, 5'b11110, M_XOR,  1'b0};
    vecs[16] = '{1, 5'b10000, M_AND,  1'b0};
    vecs[17] = '{1, 5'b00000, M_NAND, 1'b1};
    vecs[18] = '{2, 5'b00001, M_NAND, 1'b0};
    vecs[19] = '{2, 5'b00000, M_NAND, 1'b1};
    vecs[20] = '{2, 5'b00001, M_AND,  1'b1};
    vecs[21] = '{2, 5'b00000, M_OR,   1'b0};
    vecs[22] = '{2, 5'b00001, M_XOR,  1'b1};

    b2b_data = '{5'b01111, 5'b01011, 5'b00000, 5'b00111, 5'b01111, 5'b00110, 5'b01001, 5'b01000};
    for (int j = 0; j < 8; j++) b2b_mode[j] = 2'(j % 4);

    reset = 1'b1;
    din4 = '0; mode4 = '0; vin4 = 1'b0; rdy4 = 1'b1;
    din5 = '0; mode5 = '0; vin5 = 1'b0; rdy5 = 1'b1;
    din1 = '0; mode1 = '0; vin1 = 1'b0; rdy1 = 1'b1;

    // Reset state
    #12;
    chk("rst_in_ready4", 32'(irdy4), 32'd1);
    chk("rst_out_valid4", 32'(ov4), 32'd0);
    chk("rst_out_f4", 32'(f4), 32'd0);
    chk("rst_out_valid5", 32'(ov5), 32'd0);
    chk("rst_out_valid1", 32'(ov1), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Single-operand vectors
    for (int v = 0; v < 23; v++) begin
      run_vec(vecs[v].dut, vecs[v].data, vecs[v].mode, vecs[v].exp, $sformatf("vec%0d", v));
    end

    // Back-to-back, full rate
    for (int j = 0; j < 8; j++) begin
      drive(0, b2b_data[j], b2b_mode[j], 1'b1);
      @(posedge clk); #1;
      chk($sformatf("b2b_ready%0d", j), 32'(irdy4), 32'd1);
      if (j >= 1) begin
        chk($sformatf("b2b_valid%0d", j - 1), 32'(ov4), 32'd1);
        chk($sformatf("b2b_f%0d", j - 1), 32'(f4), 32'(model(b2b_data[j-1], 4, b2b_mode[j-1])));
      end
    end
    drive(0, 5'b0, M_AND, 1'b0);
    @(posedge clk); #1;
    chk("b2b_valid7", 32'(ov4), 32'd1);
    chk("b2b_f7", 32'(f4), 32'(model(b2b_data[7], 4, b2b_mode[7])));
    @(posedge clk); #1;
    chk("b2b_drain", 32'(ov4), 32'd0);

    // Asynchronous reset with two operands in flight
    drive(0, 5'b01111, M_AND, 1'b1);
    @(posedge clk); #1;
    drive(0, 5'b00001, M_OR, 1'b1);
    @(posedge clk); #1;
    drive(0, 5'b00001, M_OR, 1'b0);
    chk("mid_pre_valid", 32'(ov4), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(ov4), 32'd0);
    chk("mid_rst_f", 32'(f4), 32'd0);
    chk("mid_rst_ready", 32'(irdy4), 32'd1);
    @(posedge clk); #1;
    chk("mid_rst_hold_valid", 32'(ov4), 32'd0);
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk($sformatf("mid_no_stale%0d", k), 32'(ov4), 32'd0);
    end
    run_vec(0, 5'b00100, M_XOR, 1'b1, "mid_new");

    // Ones counter: five ones, three zeros
    #2 reset = 1'b1;
    #1;
`ifdef REDUCE_GATE_COUNT_EN
    chk("cnt_reset", 32'(cnt4), 32'd0);
`endif
    @(posedge clk); #1;
    reset = 1'b0;
    for (int j = 0; j < 8; j++) begin
      drive(0, (j < 5) ? 5'b01111 : 5'b00000, M_AND, 1'b1);
      @(posedge clk); #1;
    end
    drive(0, 5'b0, M_AND, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("cnt_drain_valid", 32'(ov4), 32'd0);
`ifdef REDUCE_GATE_COUNT_EN
    chk("cnt_five", 32'(cnt4), 32'd5);
`endif

    // Backpressure: A=OR 0010 (1) held at output, B=XOR 1100 (0), C=OR 1110 (1)
    drive(0, 5'b00010, M_OR, 1'b1);
    @(posedge clk); #1;
    drive(0, 5'b01100, M_XOR, 1'b1);
    @(posedge clk); #1;
    chk("bp_a_valid", 32'(ov4), 32'd1);
    chk("bp_a_f", 32'(f4), 32'd1);
    rdy4 = 1'b0;
    drive(0, 5'b01110, M_OR, 1'b1);
    #1;
    chk("bp_ready_drop", 32'(irdy4), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold_valid%0d", k), 32'(ov4), 32'd1);
      chk($sformatf("bp_hold_f%0d", k), 32'(f4), 32'd1);
      chk($sformatf("bp_hold_ready%0d", k), 32'(irdy4), 32'd0);
`ifdef REDUCE_GATE_COUNT_EN
      chk($sformatf("bp_hold_cnt%0d", k), 32'(cnt4), 32'd5);
`endif
    end
    rdy4 = 1'b1;
    #1;
    chk("bp_ready_back", 32'(irdy4), 32'd1);
    @(posedge clk); #1;
    drive(0, 5'b01110, M_OR, 1'b0);
    chk("bp_b_valid", 32'(ov4), 32'd1);
    chk("bp_b_f", 32'(f4), 32'd0);
`ifdef REDUCE_GATE_COUNT_EN
    chk("bp_cnt_after_a", 32'(cnt4), 32'd6);
`endif
    @(posedge clk); #1;
    chk("bp_c_valid", 32'(ov4), 32'd1);
    chk("bp_c_f", 32'(f4), 32'd1);
    @(posedge clk); #1;
    chk("bp_drain", 32'(ov4), 32'd0);
`ifdef REDUCE_GATE_COUNT_EN
    chk("bp_cnt_after_c", 32'(cnt4), 32'd7);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reduce_gate_pipe.md
Name: reduce_gate_pipe

Overview:
- Parametrised, pipelined N-input logic reduction gate: the general form of the team's two-input and four-input AND gates.
- Reduces a WIDTH-bit input vector to one bit with a run-time selectable function: AND, OR, XOR or NAND.
- Built as a balanced binary tree with one register stage per tree level.
- Valid/ready handshake on input and output, so it can sit between the lab datapath blocks and a stalling consumer.

Parameters:
- WIDTH, 4, number of input bits reduced; legal range 1..64.
- LEVELS, derived (not overridable), max(1, clog2(WIDTH)); number of pipeline stages, which equals the latency.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  WIDTH  operand bits.
- in_mode  input  2  function select: 00 AND, 01 OR, 10 XOR, 11 NAND.
- in_valid  input  1  in_data and in_mode are valid this cycle.
- in_ready  output  1  block can accept an operand this cycle.
- out_f  output  1  reduction result.
- out_valid  output  1  out_f is valid.
- out_ready  input  1  consumer accepts out_f this cycle.

Behaviour:
- Reset (asserted asynchronously, at any time):
  - all stage valid bits, out_valid and out_f clear to 0 immediately; in-flight operands are discarded;
  - in_ready goes to 1 while reset is held;
  - first acceptance is on the first rising edge after reset deasserts.
- Transfers:
  - input transfer when in_valid && in_ready;
  - output transfer when out_valid && out_ready.
- Stall: stall = out_valid && !out_ready. in_ready = !stall, combinational with no other dependency.
  - While stalled, every stage register (data, mode, valid) holds.
  - out_f and out_valid stay stable until the output transfer.
- Advance: when not stalled, every stage shifts one level. Stage 0 captures the first tree level of in_data, plus in_mode and in_valid.
  - Bubbles (valid=0) propagate and may be overwritten, so no throughput is lost on gaps.
- Latency and throughput:
  - an operand accepted at edge k produces out_valid=1 after edge k+LEVELS-1 with no stall, i.e. visible in the cycle after edge k+LEVELS-1;
  - throughput is one result per cycle.
- Mode travels with its operand through the pipeline: changing in_mode never alters operands already in flight.
- Tree construction:
  - the leaf vector is padded to 2^LEVELS bits;
  - pad bits are the identity of the base function: 1 for AND/NAND, 0 for OR/XOR;
  - each level combines adjacent pairs with the base function (NAND uses AND);
  - NAND inverts once, at the final stage only.
- WIDTH=1: single register stage. AND/OR/XOR pass the bit through, NAND inverts it, latency 1.
- WIDTH not a power of two (e.g. 5 gives LEVELS=3, pad 3 bits): the result must equal the reduction of the WIDTH real bits only.
- in_data bits are never X-propagated into the result when in_valid=0: the valid bit gates nothing in the datapath, but out_valid stays 0.
- Simultaneous output transfer and input transfer in the same cycle is legal and sustains full rate.

Optional Feature:
- Macro: REDUCE_GATE_COUNT_EN.
- With it defined, the block adds:
  - output port ones_count, 16 bits: counts output transfers where out_f=1;
  - saturates at 16'hFFFF, no wrap;
  - cleared to 0 by reset;
  - increments on the same edge as the output transfer.
- Without it defined: the port and the counter do not exist, and behaviour is otherwise identical.

Test Plan:
- WIDTH=4, out_ready=1: in_data=4'b1111 mode AND -> out_f=1 two cycles later. 4'b1011 AND -> 0. 4'b0000 OR -> 0. 4'b0111 XOR -> 1. 4'b1111 NAND -> 0.
- WIDTH=4 back-to-back: eight consecutive operands with alternating modes, in_valid held 1 -> eight results in order, one per cycle, out_valid continuous, in_ready never drops.
- Backpressure, WIDTH=4: out_ready=0 for 3 cycles while result 1 (OR of 4'b0010) is at the output:
  - out_f=1 and out_valid=1 hold;
  - in_ready=0 throughout;
  - after out_ready returns to 1, the next two queued results follow with no loss or duplication.
- WIDTH=5 padding: in_data=5'b11111 AND -> 1. 5'b10000 OR -> 1. 5'b00001 XOR -> 1, latency 3. WIDTH=1: in_data=1 NAND -> 0 after 1 cycle.
- Reset mid-flight: assert reset asynchronously between edges while 2 operands are in flight -> out_valid falls to 0 immediately, no stale result appears after release, and a new operand completes with the correct latency.
- REDUCE_GATE_COUNT_EN defined: 5 results with out_f=1 and 3 with out_f=0 -> ones_count=5. During a stall, ones_count does not increment until the transfer completes.
